// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst memory master: pattern writes and read-and-check bursts
module mem_burst_master #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic [WIDTH-1:0]      cmd_seed_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  input  logic [WIDTH-1:0]      rdata_i,
  output logic                  wr_rd_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [ADDR_WIDTH:0]   beat_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic                  err_q;
  logic [ADDR_WIDTH:0]   err_cnt_q;
  logic [ADDR_WIDTH-1:0] first_err_q;

  logic xfer;
  logic last_beat;
  logic mismatch;

  // addr_q/wdata_q advance with the beat, so the outputs come straight from flops.
  assign xfer      = (state_q == ISSUE) && ready_i;
  assign last_beat = (beat_q == len_q - 1'b1);
  assign mismatch  = !wr_q && (rdata_i != wdata_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      beat_q      <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            wr_q        <= cmd_wr_i;
            addr_q      <= cmd_addr_i;
            wdata_q     <= cmd_seed_i;
            beat_q      <= '0;
            len_q       <= (cmd_len_i > DEPTH_L) ? DEPTH_L : cmd_len_i;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            state_q     <= (cmd_len_i == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (xfer) begin
            if (mismatch) begin
              err_q     <= 1'b1;
              err_cnt_q <= err_cnt_q + 1'b1;
              if (!err_q) first_err_q <= addr_q;
            end
            beat_q  <= beat_q + 1'b1;
            addr_q  <= addr_q + 1'b1;
            wdata_q <= wdata_q + 1'b1;
            if (last_beat) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o      = (state_q == IDLE);
  assign busy_o           = (state_q != IDLE);
  assign valid_o          = (state_q == ISSUE);
  assign done_o           = (state_q == DONE);
  assign wr_rd_o          = wr_q;
  assign addr_o           = addr_q;
  assign wdata_o          = wdata_q;
  assign err_o            = err_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// tb/tb_mem_burst_master.sv - directed self-checking bench for mem_burst_master
module tb_mem_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [3:0]  cmd_addr;
  logic [4:0]  cmd_len;
  logic [15:0] cmd_seed;
  logic [3:0]  addr_o;
  logic [15:0] wdata_o;
  logic [15:0] rdata;
  logic        wr_rd_o;
  logic        valid_o;
  logic        ready;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [4:0]  err_cnt_o;
  logic [3:0]  first_err_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_a  = '0;
  logic [15:0] poke_d  = '0;

  int          n_xfer, done_cyc, valid_cnt, rdy_busy_bad;
  logic        stable_ok, done_after, rdy_after, valid_at_done;
  logic [3:0]  obs_addr  [32];
  logic [15:0] obs_wdata [32];
  logic        obs_wr    [32];

  always #5 clk = ~clk;

  mem_burst_master #(.WIDTH(16), .DEPTH(16), .ADDR_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wr_i(cmd_wr),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_seed_i(cmd_seed),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata), .wr_rd_o(wr_rd_o),
    .valid_o(valid_o), .ready_i(ready), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_o)
  );

  assign rdata = mem[addr_o];

  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    else if (valid_o && ready && wr_rd_o) mem[addr_o] <= wdata_o;
  end

  task automatic poke(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Issues one command and records what the DUT does; cycle 1 is the first cycle after the accept edge.
  task automatic run_cmd(input logic wr, input logic [3:0] a, input logic [4:0] len,
                         input logic [15:0] seed, input int stall_beat, input int stall_n);
    int   cyc;
    int   stall_left;
    logic stalled_prev;
    logic [3:0]  p_addr;
    logic [15:0] p_wdata;
    logic        p_wr;
    @(negedge clk);
    cmd_wr = wr; cmd_addr = a; cmd_len = len; cmd_seed = seed; cmd_valid = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 1; stall_left = stall_n; stalled_prev = 1'b0;
    p_addr = '0; p_wdata = '0; p_wr = 1'b0;
    n_xfer = 0; done_cyc = -1; valid_cnt = 0; rdy_busy_bad = 0;
    stable_ok = 1'b1; valid_at_done = 1'b0;
    while (cyc < 60) begin
      if (stalled_prev && (valid_o !== 1'b1 || addr_o !== p_addr || wdata_o !== p_wdata || wr_rd_o !== p_wr))
        stable_ok = 1'b0;
      if (valid_o && n_xfer == stall_beat && stall_left > 0) begin
        ready = 1'b0; stall_left--; stalled_prev = 1'b1;
        p_addr = addr_o; p_wdata = wdata_o; p_wr = wr_rd_o;
      end else begin
        ready = 1'b1; stalled_prev = 1'b0;
      end
      if (cmd_ready) rdy_busy_bad++;
      if (valid_o) valid_cnt++;
      if (valid_o && ready && n_xfer < 32) begin
        obs_addr[n_xfer] = addr_o; obs_wdata[n_xfer] = wdata_o; obs_wr[n_xfer] = wr_rd_o;
        n_xfer++;
      end
      if (done_o) begin
        done_cyc = cyc; valid_at_done = valid_o;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ready = 1'b1;
    @(posedge clk); #1;
    done_after = done_o;
    rdy_after  = cmd_ready;
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_seed = '0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid_o); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready); end
    checks++; if ({busy_o, done_o, err_o, wr_rd_o} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {busy_o, done_o, err_o, wr_rd_o}); end
    checks++; if ({addr_o, wdata_o, err_cnt_o, first_err_o} !== 29'd0) begin errors++; $display("FAIL reset_data: got %h exp 0", {addr_o, wdata_o, err_cnt_o, first_err_o}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_write_wrap();
    run_cmd(1'b1, 4'd5, 5'd16, 16'h1000, -1, 0);
    checks++; if (n_xfer !== 16) begin errors++; $display("FAIL wrap_xfers: got %0d exp 16", n_xfer); end
    checks++; if (done_cyc !== 17) begin errors++; $display("FAIL wrap_done_cycle: got %0d exp 17", done_cyc); end
    for (int i = 0; i < 16; i++) begin
      logic [3:0]  ea;
      logic [15:0] ed;
      ea = 4'(5 + i);
      ed = 16'h1000 + 16'(i);
      checks++;
      if (obs_addr[i] !== ea || obs_wdata[i] !== ed || obs_wr[i] !== 1'b1) begin
        errors++; $display("FAIL wrap_beat%0d: got a=%h d=%h w=%b exp a=%h d=%h w=1", i, obs_addr[i], obs_wdata[i], obs_wr[i], ea, ed);
      end
    end
    checks++; if (err_cnt_o !== 5'd0 || err_o !== 1'b0) begin errors++; $display("FAIL wrap_err: got cnt=%0d err=%b exp 0/0", err_cnt_o, err_o); end
    checks++; if (done_after !== 1'b0 || rdy_after !== 1'b1) begin errors++; $display("FAIL wrap_after_done: got done=%b rdy=%b exp 0/1", done_after, rdy_after); end
    checks++; if (rdy_busy_bad !== 0 || valid_at_done !== 1'b0) begin errors++; $display("FAIL wrap_busy_ready: got rdy_cycles=%0d vdone=%b exp 0/0", rdy_busy_bad, valid_at_done); end
  endtask

  task automatic test_read_back();
    run_cmd(1'b0, 4'd5, 5'd16, 16'h1000, -1, 0);
    checks++; if (done_cyc !== 17) begin errors++; $display("FAIL rb_done_cycle: got %0d exp 17", done_cyc); end
    checks++; if (err_o !== 1'b0 || err_cnt_o !== 5'd0) begin errors++; $display("FAIL rb_err: got err=%b cnt=%0d exp 0/0", err_o, err_cnt_o); end
    checks++; if (obs_wr[0] !== 1'b0 || obs_wr[15] !== 1'b0) begin errors++; $display("FAIL rb_wr_rd: got %b%b exp 00", obs_wr[0], obs_wr[15]); end
  endtask

  task automatic test_corruption();
    poke(4'd7, 16'hDEAD);
    run_cmd(1'b0, 4'd5, 5'd16, 16'h1000, -1, 0);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL corr_err: got %b exp 1", err_o); end
    checks++; if (err_cnt_o !== 5'd1) begin errors++; $display("FAIL corr_cnt: got %0d exp 1", err_cnt_o); end
    checks++; if (first_err_o !== 4'd7) begin errors++; $display("FAIL corr_first: got %0d exp 7", first_err_o); end
    poke(4'd9, 16'hBEEF);
    poke(4'd2, 16'h0000);
    run_cmd(1'b0, 4'd5, 5'd16, 16'h1000, -1, 0);
    checks++; if (err_cnt_o !== 5'd3) begin errors++; $display("FAIL corr3_cnt: got %0d exp 3", err_cnt_o); end
    checks++; if (first_err_o !== 4'd7) begin errors++; $display("FAIL corr3_first: got %0d exp 7", first_err_o); end
  endtask

  task automatic test_stall();
    run_cmd(1'b1, 4'd0, 5'd4, 16'h2000, 2, 3);
    checks++; if (done_cyc !== 8) begin errors++; $display("FAIL stall_done_cycle: got %0d exp 8", done_cyc); end
    checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL stall_stable: got %b exp 1", stable_ok); end
    checks++; if (valid_cnt !== 7 || n_xfer !== 4) begin errors++; $display("FAIL stall_counts: got v=%0d x=%0d exp 7/4", valid_cnt, n_xfer); end
    checks++; if (obs_addr[2] !== 4'd2 || obs_wdata[2] !== 16'h2002) begin errors++; $display("FAIL stall_beat2: got a=%h d=%h exp 2/2002", obs_addr[2], obs_wdata[2]); end
  endtask

  task automatic test_zero_len();
    run_cmd(1'b1, 4'd3, 5'd0, 16'h5555, -1, 0);
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL zero_valid: got %0d exp 0", valid_cnt); end
    checks++; if (done_cyc !== 1) begin errors++; $display("FAIL zero_done_cycle: got %0d exp 1", done_cyc); end
    checks++; if (rdy_after !== 1'b1) begin errors++; $display("FAIL zero_ready_after: got %b exp 1", rdy_after); end
  endtask

  task automatic test_clamp();
    run_cmd(1'b1, 4'd3, 5'd20, 16'h3000, -1, 0);
    checks++; if (n_xfer !== 16 || done_cyc !== 17) begin errors++; $display("FAIL clamp_len: got x=%0d d=%0d exp 16/17", n_xfer, done_cyc); end
    checks++; if (obs_addr[15] !== 4'd2 || obs_wdata[15] !== 16'h300F) begin errors++; $display("FAIL clamp_last: got a=%h d=%h exp 2/300f", obs_addr[15], obs_wdata[15]); end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    cmd_wr = 1'b0; cmd_addr = 4'd1; cmd_len = 5'd16; cmd_seed = 16'h4000; cmd_valid = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (valid_o !== 1'b1 || addr_o !== 4'd5 || err_cnt_o !== 5'd4) begin errors++; $display("FAIL mid_beat4: got v=%b a=%h c=%0d exp 1/5/4", valid_o, addr_o, err_cnt_o); end
    rst = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_async: got v=%b b=%b r=%b exp 0/0/1", valid_o, busy_o, cmd_ready); end
    checks++; if (err_o !== 1'b0 || err_cnt_o !== 5'd0 || first_err_o !== 4'd0) begin errors++; $display("FAIL mid_err_clear: got e=%b c=%0d f=%0d exp 0/0/0", err_o, err_cnt_o, first_err_o); end
    @(posedge clk); #1;
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mid_no_done: got %b exp 0", done_o); end
    @(negedge clk);
    rst = 1'b1;
    cmd_wr = 1'b1; cmd_addr = 4'd8; cmd_len = 5'd2; cmd_seed = 16'h5000; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if (valid_o !== 1'b1 || addr_o !== 4'd8 || wdata_o !== 16'h5000) begin errors++; $display("FAIL mid_first_accept: got v=%b a=%h d=%h exp 1/8/5000", valid_o, addr_o, wdata_o); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL mid_rerun_done: got %b exp 1", done_o); end
    @(posedge clk); #1;
    run_cmd(1'b0, 4'd8, 5'd2, 16'h5000, -1, 0);
    checks++; if (done_cyc !== 3 || err_o !== 1'b0) begin errors++; $display("FAIL mid_readback: got d=%0d e=%b exp 3/0", done_cyc, err_o); end
  endtask

  initial begin
    test_reset();
    test_write_wrap();
    test_read_back();
    test_corruption();
    test_stall();
    test_zero_len();
    test_clamp();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_burst_master.md
MEM_BURST_MASTER -- requirements
Module: mem_burst_master

Interface
REQ-001 Parameters SHALL be: WIDTH, 16, memory data width; DEPTH, 16, memory locations; ADDR_WIDTH, 4, address width (DEPTH = 2**ADDR_WIDTH).
REQ-002 Ports SHALL be, one per entry:
- clk_i  in  1  single clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when both high at a rising edge.
- cmd_wr_i  in  1  1 = write burst, 0 = read-and-check burst.
- cmd_addr_i  in  ADDR_WIDTH  start address.
- cmd_len_i  in  ADDR_WIDTH+1  beat count, 0..DEPTH.
- cmd_seed_i  in  WIDTH  pattern seed.
- addr_o  out  ADDR_WIDTH  memory address.
- wdata_o  out  WIDTH  memory write data.
- rdata_i  in  WIDTH  memory read data.
- wr_rd_o  out  1  1 = write, 0 = read.
- valid_o  out  1  memory request.
- ready_i  in  1  memory completion.
- busy_o  out  1  high while not IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  mismatch seen in the last read burst.
- err_cnt_o  out  ADDR_WIDTH+1  mismatch count.
- first_err_addr_o  out  ADDR_WIDTH  address of the first mismatch.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE and DONE. IDLE is the reset state.
REQ-004 In IDLE, cmd_ready_o SHALL be 1. In every other state it SHALL be 0.
REQ-005 On command accept:
- latch cmd_wr_i, cmd_addr_i, cmd_len_i and cmd_seed_i;
- clear the beat index, err_o, err_cnt_o and first_err_addr_o;
- go to DONE if cmd_len_i == 0, otherwise go to ISSUE.
REQ-006 In ISSUE, outputs SHALL be:
- valid_o = 1;
- wr_rd_o = the latched wr;
- addr_o = (start + beat) mod DEPTH, wrapping from DEPTH-1 to 0;
- wdata_o = (seed + beat) mod 2**WIDTH.
REQ-007 A beat SHALL transfer only in a cycle where valid_o && ready_i at a rising edge. addr_o, wdata_o and wr_rd_o SHALL hold stable while valid_o is high and ready_i is low.
REQ-008 On each transfer, the beat index SHALL increment. On the transfer where beat == len-1, the FSM SHALL go to DONE, and valid_o SHALL be 0 in the following cycle.
REQ-009 On a read transfer, rdata_i SHALL be sampled in the handshake cycle and compared with (seed + beat) mod 2**WIDTH. On a mismatch:
- err_o is set and stays high until the next accept;
- err_cnt_o increments (it needs no saturation, because len <= DEPTH);
- if this is the first mismatch, first_err_addr_o captures addr_o.
REQ-010 Write bursts SHALL never alter err_o, err_cnt_o or first_err_addr_o after they are cleared at accept.
REQ-011 DONE SHALL:
- assert done_o for exactly one cycle;
- keep valid_o = 0;
- return to IDLE unconditionally.
REQ-012 Latency, with ready_i held at 1:
- accept edge at cycle N;
- valid_o high in cycles N+1 .. N+len;
- done_o high in cycle N+len+1;
- cmd_ready_o high again in cycle N+len+2.
For len == 0, done_o SHALL be high in cycle N+1.
REQ-013 busy_o SHALL be 1 in ISSUE and DONE, and 0 in IDLE.
REQ-014 cmd_valid_i SHALL be ignored while cmd_ready_o is 0. No command queuing is required.
REQ-015 When cmd_len_i > DEPTH, the value SHALL be clamped to DEPTH at accept.
REQ-016 Outputs SHALL be driven only from registers or from state decode. There SHALL be no combinational path from ready_i to valid_o.

Reset
REQ-017 While rst_i is 0, the block SHALL immediately (asynchronously) enter IDLE.
REQ-018 While rst_i is 0, output values SHALL be:
- valid_o, wr_rd_o, addr_o, wdata_o, done_o, busy_o, err_o, err_cnt_o and first_err_addr_o = 0;
- cmd_ready_o = 1.
REQ-019 A reset asserted mid-burst SHALL abandon the burst with no done_o pulse. The first command SHALL be accepted at the first rising edge after rst_i returns to 1.

Verification
REQ-020 Write wrap: addr 5, len 16, seed 0x1000, ready_i=1 -> 16 transfers at addr 5..15,0..4 with wdata 0x1000..0x100F; done_o at N+17; err_cnt_o=0.
REQ-021 Read-back: same command with wr=0 against a memory model holding the data from REQ-020 -> err_o=0, err_cnt_o=0, done_o at N+17.
REQ-022 Corruption: model location 7 altered to 0xDEAD, then read burst addr 5, len 16, seed 0x1000 -> err_o=1, err_cnt_o=1, first_err_addr_o=7.
REQ-023 Stall: ready_i held low for 3 cycles on beat 2 -> valid_o, addr_o and wdata_o stable for those cycles; done_o delayed by 3 cycles.
REQ-024 Zero length: cmd_len_i=0 -> valid_o never asserted; done_o high in N+1.
REQ-025 Reset mid-burst: rst_i low during beat 4 -> valid_o=0 and busy_o=0 at once with no done_o; after release, a new command is accepted and runs normally.
